// File: rtl/phy_multilane_link_pkg.sv
// Shared constants and RX alignment state encoding for the multilane PHY core.
package phy_multilane_link_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BIT_CNT_W   = 3;
  localparam logic [7:0]  COM_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    RX_SEARCH = 2'd0,
    RX_CHECK  = 2'd1,
    RX_LOCKED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_lane_shift.sv
// One serial lane: MSB-first TX shift register and an 8-bit RX sampling window.
module phy_lane_shift
  import phy_multilane_link_pkg::*;
#(
  parameter logic [7:0] COM = COM_DEFAULT
) (
  input  logic                clk_32f,
  input  logic                reset,
  input  logic                load,
  input  logic [BYTE_W-1:0]   load_byte,
  input  logic                rx_bit,
  output logic                tx_bit,
  output logic [BYTE_W-1:0]   rx_window
);

  logic [BYTE_W-1:0] tx_shreg;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      tx_shreg  <= COM;
      rx_window <= '0;
    end else begin
      tx_shreg  <= load ? load_byte : {tx_shreg[BYTE_W-2:0], 1'b0};
      rx_window <= {rx_window[BYTE_W-2:0], rx_bit};
    end
  end

  assign tx_bit = tx_shreg[BYTE_W-1];

endmodule

// File: rtl/phy_multilane_link.sv
// Multilane PHY: stripes words across serial lanes with COM idles, aligns RX on
// lane-0 COM symbols and rebuilds the parallel word once locked.
module phy_multilane_link
  import phy_multilane_link_pkg::*;
#(
  parameter  int unsigned LANES    = 4,
  parameter  logic [7:0]  COM      = COM_DEFAULT,
  parameter  int unsigned SYNC_COM = 4,
  localparam int unsigned DATA_W   = BYTE_W * LANES
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [LANES-1:0]  serial_tx,
  input  logic [LANES-1:0]  serial_rx,
  input  logic              resync,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              sincronizar_bus
);

  localparam int unsigned COM_CNT_W = $clog2(SYNC_COM + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

  logic [BIT_CNT_W-1:0] tx_cnt;
  logic [BIT_CNT_W-1:0] rx_cnt;
  logic [COM_CNT_W-1:0] com_cnt;
  rx_state_e            state;
  logic [DATA_W-1:0]    tx_word;
  logic [DATA_W-1:0]    rx_word;
  logic                 boundary;
  logic                 lane0_com;
  logic                 all_com;

  assign ready_in  = (tx_cnt == LAST_BIT);
  assign tx_word   = valid_in ? data_in : {LANES{COM}};
  assign boundary  = (rx_cnt == LAST_BIT);
  assign lane0_com = (rx_word[BYTE_W-1:0] == COM);
  assign all_com   = (rx_word == {LANES{COM}});

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    phy_lane_shift #(
      .COM (COM)
    ) u_lane (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .load      (ready_in),
      .load_byte (tx_word[BYTE_W*l +: BYTE_W]),
      .rx_bit    (serial_rx[l]),
      .tx_bit    (serial_tx[l]),
      .rx_window (rx_word[BYTE_W*l +: BYTE_W])
    );
  end

  // Bit counters, alignment FSM and word assembly; resync overrides everything RX-side.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      tx_cnt          <= LAST_BIT;
      rx_cnt          <= '0;
      com_cnt         <= '0;
      state           <= RX_SEARCH;
      data_out        <= '0;
      valid_out       <= 1'b0;
      sincronizar_bus <= 1'b0;
    end else begin
      tx_cnt    <= tx_cnt + BIT_CNT_W'(1);
      rx_cnt    <= rx_cnt + BIT_CNT_W'(1);
      valid_out <= 1'b0;
      if (resync) begin
        state           <= RX_SEARCH;
        com_cnt         <= '0;
        sincronizar_bus <= 1'b0;
      end else begin
        case (state)
          RX_SEARCH: begin
            if (lane0_com) begin
              rx_cnt  <= '0;
              com_cnt <= COM_CNT_W'(1);
              state   <= RX_CHECK;
            end
          end
          RX_CHECK: begin
            if (boundary) begin
              if (lane0_com) begin
                com_cnt <= com_cnt + COM_CNT_W'(1);
                if (com_cnt == COM_CNT_W'(SYNC_COM - 1)) begin
                  state           <= RX_LOCKED;
                  sincronizar_bus <= 1'b1;
                end
              end else begin
                com_cnt <= '0;
                state   <= RX_SEARCH;
              end
            end
          end
          RX_LOCKED: begin
            // All-COM frames are idle and leave the last word on data_out.
            if (boundary && !all_com) begin
              data_out  <= rx_word;
              valid_out <= 1'b1;
            end
          end
          default: state <= RX_SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phy_multilane_link.sv
// Loopback bench for phy_multilane_link at 4, 2 and 1 lanes; expected words and
// arrival cycles are queued at accept time and popped by per-DUT monitors.
module tb_phy_multilane_link;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;
  always #5 clk_32f = ~clk_32f;

  int cyc = 0;
  always @(posedge clk_32f) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int dly4   = 0;

  exp_t q4[$];
  exp_t q2[$];
  exp_t q1[$];

  logic [31:0] din4 = '0;
  logic        vin4 = 1'b0, rsy4 = 1'b0;
  logic        rdy4, vout4, sync4;
  logic [3:0]  stx4, srx4;
  logic [31:0] dout4;

  logic [15:0] din2 = '0;
  logic        vin2 = 1'b0, rsy2 = 1'b0;
  logic        rdy2, vout2, sync2;
  logic [1:0]  stx2;
  logic [15:0] dout2;

  logic [7:0]  din1 = '0;
  logic        vin1 = 1'b0, rsy1 = 1'b0;
  logic        rdy1, vout1, sync1;
  logic [0:0]  stx1;
  logic [7:0]  dout1;

  logic [3:0]  pipe4 [8];

  always @(posedge clk_32f) begin
    pipe4[0] <= stx4;
    for (int i = 1; i < 8; i++) pipe4[i] <= pipe4[i-1];
  end

  always_comb srx4 = (dly4 == 0) ? stx4 : pipe4[dly4-1];

  phy_multilane_link #(.LANES(4), .COM(8'hBC), .SYNC_COM(4)) u_dut4 (
    .clk_32f(clk_32f), .reset(reset), .data_in(din4), .valid_in(vin4),
    .ready_in(rdy4), .serial_tx(stx4), .serial_rx(srx4), .resync(rsy4),
    .data_out(dout4), .valid_out(vout4), .sincronizar_bus(sync4));

  phy_multilane_link #(.LANES(2), .COM(8'hBC), .SYNC_COM(4)) u_dut2 (
    .clk_32f(clk_32f), .reset(reset), .data_in(din2), .valid_in(vin2),
    .ready_in(rdy2), .serial_tx(stx2), .serial_rx(stx2), .resync(rsy2),
    .data_out(dout2), .valid_out(vout2), .sincronizar_bus(sync2));

  phy_multilane_link #(.LANES(1), .COM(8'hBC), .SYNC_COM(4)) u_dut1 (
    .clk_32f(clk_32f), .reset(reset), .data_in(din1), .valid_in(vin1),
    .ready_in(rdy1), .serial_tx(stx1), .serial_rx(stx1), .resync(rsy1),
    .data_out(dout1), .valid_out(vout1), .sincronizar_bus(sync1));

  function automatic logic ready_of(input int u);
    case (u)
      0:       return rdy4;
      1:       return rdy2;
      default: return rdy1;
    endcase
  endfunction

  function automatic logic sync_of(input int u);
    case (u)
      0:       return sync4;
      1:       return sync2;
      default: return sync1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Called at a negedge; holds valid until ready is seen, then the next edge accepts.
  task automatic send(input int u, input logic [31:0] d, input bit expect_out);
    int   n;
    logic r;
    exp_t e;
    n = 0;
    case (u)
      0:       begin din4 = d;        vin4 = 1'b1; end
      1:       begin din2 = d[15:0];  vin2 = 1'b1; end
      default: begin din1 = d[7:0];   vin1 = 1'b1; end
    endcase
    r = ready_of(u);
    while (!r && n < 16) begin
      @(negedge clk_32f);
      n++;
      r = ready_of(u);
    end
    checks++;
    if (!r) begin
      errors++;
      $display("FAIL accept_timeout unit=%0d got ready_in=0 want 1", u);
    end else if (expect_out) begin
      e.d = d;
      e.c = cyc + 10 + ((u == 0) ? dly4 : 0);
      case (u)
        0:       q4.push_back(e);
        1:       q2.push_back(e);
        default: q1.push_back(e);
      endcase
    end
    @(negedge clk_32f);
    case (u)
      0:       vin4 = 1'b0;
      1:       vin2 = 1'b0;
      default: vin1 = 1'b0;
    endcase
  endtask

  task automatic wait_lock(input int u, input int budget, input string tag);
    int n;
    n = 0;
    while (!sync_of(u) && n < budget) begin
      @(negedge clk_32f);
      n++;
    end
    checks++;
    if (!sync_of(u)) begin
      errors++;
      $display("FAIL %s sincronizar_bus got 0 after %0d cycles want 1", tag, n);
    end
  endtask

  always @(negedge clk_32f) begin : mon4
    exp_t e;
    if (vout4 === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid4 got data_out=%h at cycle %0d want no valid_out", dout4, cyc);
      end else begin
        e = q4.pop_front();
        if (dout4 !== e.d || cyc != e.c) begin
          errors++;
          $display("FAIL rx_word4 got %h at cycle %0d want %h at cycle %0d", dout4, cyc, e.d, e.c);
        end
      end
    end
  end

  always @(negedge clk_32f) begin : mon2
    exp_t e;
    if (vout2 === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid2 got data_out=%h at cycle %0d want no valid_out", dout2, cyc);
      end else begin
        e = q2.pop_front();
        if (dout2 !== e.d[15:0] || cyc != e.c) begin
          errors++;
          $display("FAIL rx_word2 got %h at cycle %0d want %h at cycle %0d", dout2, cyc, e.d[15:0], e.c);
        end
      end
    end
  end

  always @(negedge clk_32f) begin : mon1
    exp_t e;
    if (vout1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid1 got data_out=%h at cycle %0d want no valid_out", dout1, cyc);
      end else begin
        e = q1.pop_front();
        if (dout1 !== e.d[7:0] || cyc != e.c) begin
          errors++;
          $display("FAIL rx_word1 got %h at cycle %0d want %h at cycle %0d", dout1, cyc, e.d[7:0], e.c);
        end
      end
    end
  end

  initial begin
    // Reset held for three cycles with idle inputs.
    repeat (3) @(negedge clk_32f);
    chk("rst_data_out",  dout4, 32'h0);
    chk("rst_valid_out", 32'(vout4), 32'h0);
    chk("rst_sync4",     32'(sync4), 32'h0);
    chk("rst_serial_tx", 32'(stx4), 32'hF);
    chk("rst_ready_in",  32'(rdy4), 32'h1);
    chk("rst_sync2",     32'(sync2), 32'h0);
    chk("rst_sync1",     32'(sync1), 32'h0);
    reset = 1'b1;
    wait_lock(0, 48, "lock4");
    wait_lock(1, 48, "lock2");
    wait_lock(2, 48, "lock1");

    // Back-to-back words at each lane count.
    send(0, 32'hDEADBEEF, 1'b1);
    send(0, 32'h01234567, 1'b1);
    send(1, 32'h000055AA, 1'b1);
    send(1, 32'h00001234, 1'b1);
    send(2, 32'h0000003C, 1'b1);
    send(2, 32'h000000C3, 1'b1);
    repeat (20) @(negedge clk_32f);

    // Switch the loopback to 3 cycles of delay and realign.
    dly4 = 3;
    rsy4 = 1'b1;
    @(negedge clk_32f);
    rsy4 = 1'b0;
    chk("resync_delay_sync", 32'(sync4), 32'h0);
    wait_lock(0, 64, "lock4_delayed");
    send(0, 32'hA5A50F0F, 1'b1);
    repeat (16) @(negedge clk_32f);

    // Resync while a word is in flight: it must be dropped.
    send(0, 32'h12345678, 1'b0);
    repeat (3) @(negedge clk_32f);
    rsy4 = 1'b1;
    @(negedge clk_32f);
    rsy4 = 1'b0;
    chk("resync_sync",  32'(sync4), 32'h0);
    chk("resync_valid", 32'(vout4), 32'h0);
    wait_lock(0, 64, "relock4");
    send(0, 32'h0BADF00D, 1'b1);
    repeat (16) @(negedge clk_32f);

    // Reset mid-word at tx_cnt==3.
    send(0, 32'hCAFEF00D, 1'b0);
    repeat (3) @(negedge clk_32f);
    reset = 1'b0;
    #1;
    chk("midrst_data_out",  dout4, 32'h0);
    chk("midrst_valid_out", 32'(vout4), 32'h0);
    chk("midrst_sync4",     32'(sync4), 32'h0);
    chk("midrst_serial_tx", 32'(stx4), 32'hF);
    chk("midrst_ready_in",  32'(rdy4), 32'h1);
    chk("midrst_data_out2", 32'(dout2), 32'h0);
    chk("midrst_sync1",     32'(sync1), 32'h0);
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
    wait_lock(0, 64, "lock4_after_rst");
    wait_lock(1, 64, "lock2_after_rst");
    wait_lock(2, 64, "lock1_after_rst");
    send(0, 32'h13579BDF, 1'b1);
    send(1, 32'h0000BEEF, 1'b1);
    send(2, 32'h000000A5, 1'b1);
    repeat (20) @(negedge clk_32f);

    // An all-COM data word looks like idle: nothing emitted, data_out holds.
    send(0, 32'hBCBCBCBC, 1'b0);
    repeat (20) @(negedge clk_32f);
    chk("allcom_hold", dout4, 32'h13579BDF);

    chk("pending4", 32'(q4.size()), 32'h0);
    chk("pending2", 32'(q2.size()), 32'h0);
    chk("pending1", 32'(q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
